// File: rtl/vector_compress_unit_pkg.sv
`default_nettype none
// ============================================================================
// Package   : riscv_v_pkg
// Purpose   : Vector architecture constants shared by vector execution units.
// Contents  : VLEN (vector register width in bits).
// Revision  : 1.0 - initial release
// ============================================================================
package riscv_v_pkg;

  localparam int VLEN = 128;

endpackage : riscv_v_pkg

// ============================================================================
// Package   : dragonfang_pkg
// Purpose   : Types, constants and element helpers for vector_compress_unit.
// Contents  : compress_state_t, vsew_e, VLMAX_E8, index widths,
//             element extract/insert and vl clamp functions.
// Revision  : 1.0 - initial release
// ============================================================================
package dragonfang_pkg;

  import riscv_v_pkg::*;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } compress_state_t;

  typedef enum logic [1:0] {
    SEW_E8  = 2'b00,
    SEW_E16 = 2'b01,
    SEW_E32 = 2'b10,
    SEW_E64 = 2'b11
  } vsew_e;

  localparam int VLMAX_E8 = VLEN / 8;
  // Element index / vl width: enough for 0..VLMAX_E8 inclusive.
  localparam int VLW      = $clog2(VLMAX_E8) + 1;
  // Bit offset width inside a VLEN-wide register.
  localparam int OFFW     = $clog2(VLEN);

  function automatic logic [63:0] elem_mask(input logic [1:0] sew);
    logic [63:0] m;
    case (sew)
      SEW_E8:  m = 64'h0000_0000_0000_00FF;
      SEW_E16: m = 64'h0000_0000_0000_FFFF;
      SEW_E32: m = 64'h0000_0000_FFFF_FFFF;
      default: m = 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
    return m;
  endfunction

  // Bit offset of element idx. Callers keep idx below VLEN/SEW, so the
  // truncation to OFFW bits never drops a meaningful bit.
  function automatic logic [OFFW-1:0] elem_offset(input logic [1:0]     sew,
                                                  input logic [VLW-1:0] idx);
    logic [OFFW-1:0] base;
    base = OFFW'({idx, 3'b000});
    return base << sew;
  endfunction

  function automatic logic [63:0] elem_extract(input logic [VLEN-1:0] vec,
                                               input logic [1:0]      sew,
                                               input logic [VLW-1:0]  idx);
    logic [VLEN-1:0] sh;
    sh = vec >> elem_offset(sew, idx);
    return sh[63:0] & elem_mask(sew);
  endfunction

  function automatic logic [VLEN-1:0] elem_insert(input logic [VLEN-1:0] vec,
                                                  input logic [1:0]      sew,
                                                  input logic [VLW-1:0]  idx,
                                                  input logic [63:0]     data);
    logic [VLEN-1:0] m;
    logic [VLEN-1:0] d;
    logic [OFFW-1:0] off;
    off = elem_offset(sew, idx);
    m   = {{(VLEN-64){1'b0}}, elem_mask(sew)} << off;
    d   = {{(VLEN-64){1'b0}}, data & elem_mask(sew)} << off;
    return (vec & ~m) | d;
  endfunction

  // VLMAX = VLEN/SEW = VLMAX_E8 >> vsew.
  function automatic logic [VLW-1:0] clamp_vl(input logic [VLW-1:0] vl,
                                              input logic [1:0]     sew);
    logic [VLW-1:0] vlmax;
    vlmax = VLW'(VLMAX_E8) >> sew;
    return (vl > vlmax) ? vlmax : vl;
  endfunction

endpackage : dragonfang_pkg
`default_nettype wire

// File: rtl/vector_compress_unit_freq.sv
`default_nettype none
// ============================================================================
// Module    : vector_compress_unit_freq
// Purpose   : Timing-characterisation shell: every input and output of
//             vector_compress_unit passes through a register stage, so the
//             core's paths are bounded by flops on both sides. Adds one
//             cycle of latency on the way in and one on the way out.
// Ports     : identical in name and meaning to vector_compress_unit.
// Revision  : 1.0 - initial release
// ============================================================================
module vector_compress_unit_freq
  import riscv_v_pkg::*;
  import dragonfang_pkg::*;
(
  input  logic            clock,
  input  logic            reset_n,
  input  logic            start,
  input  logic [1:0]      vsew,
  input  logic [VLW-1:0]  vl,
  input  logic [VLEN-1:0] vs2,
  input  logic [VLEN-1:0] vs1,
  input  logic [VLEN-1:0] vd_old,
  output logic            busy,
  output logic            done,
  output logic [VLEN-1:0] vd
);

  logic            in_start;
  logic [1:0]      in_vsew;
  logic [VLW-1:0]  in_vl;
  logic [VLEN-1:0] in_vs2;
  logic [VLEN-1:0] in_vs1;
  logic [VLEN-1:0] in_vd_old;

  logic            core_busy;
  logic            core_done;
  logic [VLEN-1:0] core_vd;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      in_start  <= 1'b0;
      in_vsew   <= '0;
      in_vl     <= '0;
      in_vs2    <= '0;
      in_vs1    <= '0;
      in_vd_old <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      vd        <= '0;
    end else begin
      in_start  <= start;
      in_vsew   <= vsew;
      in_vl     <= vl;
      in_vs2    <= vs2;
      in_vs1    <= vs1;
      in_vd_old <= vd_old;
      busy      <= core_busy;
      done      <= core_done;
      vd        <= core_vd;
    end
  end

  vector_compress_unit u_core (
    .clock   (clock),
    .reset_n (reset_n),
    .start   (in_start),
    .vsew    (in_vsew),
    .vl      (in_vl),
    .vs2     (in_vs2),
    .vs1     (in_vs1),
    .vd_old  (in_vd_old),
    .busy    (core_busy),
    .done    (core_done),
    .vd      (core_vd)
  );

endmodule : vector_compress_unit_freq
`default_nettype wire

// File: rtl/vector_compress_unit.sv
`default_nettype none
// ============================================================================
// Module    : vector_compress_unit
// Purpose   : vcompress.vm - packs mask-selected elements of vs2 into the low
//             elements of vd, one source element per cycle; elements above
//             the packed count keep vd_old (tail-undisturbed).
// Ports     : clock   - clock, all state on rising edge
//             reset_n - asynchronous active-low reset
//             start   - one-cycle request, sampled in IDLE only
//             vsew    - element width (00=e8 01=e16 10=e32 11=e64)
//             vl      - active element count (clamped to VLEN/SEW)
//             vs2     - source elements
//             vs1     - selection mask, bit i selects element i
//             vd_old  - prior destination contents
//             busy    - high in RUN and DONE
//             done    - one-cycle pulse, vd valid
//             vd      - packed result, held until the next done
// Revision  : 1.0 - initial release
// ============================================================================
module vector_compress_unit
  import riscv_v_pkg::*;
  import dragonfang_pkg::*;
(
  input  logic            clock,
  input  logic            reset_n,
  input  logic            start,
  input  logic [1:0]      vsew,
  input  logic [VLW-1:0]  vl,
  input  logic [VLEN-1:0] vs2,
  input  logic [VLEN-1:0] vs1,
  input  logic [VLEN-1:0] vd_old,
  output logic            busy,
  output logic            done,
  output logic [VLEN-1:0] vd
);

  compress_state_t state;
  compress_state_t state_nxt;

  logic [VLEN-1:0] cap_vs2;
  logic [VLEN-1:0] cap_vs1;
  logic [1:0]      cap_sew;
  logic [VLW-1:0]  cap_vl;
  logic [VLEN-1:0] work;      // result under construction, seeded with vd_old
  logic [VLW-1:0]  rd_idx;
  logic [VLW-1:0]  wr_idx;

  logic [VLW-1:0]  vl_clamped;
  logic [OFFW-1:0] rd_bit;
  logic            sel;
  logic            last;
  logic [VLEN-1:0] work_ins;

  assign vl_clamped = clamp_vl(vl, vsew);
  assign rd_bit     = OFFW'(rd_idx);
  assign sel        = cap_vs1[rd_bit];
  assign last       = (rd_idx + VLW'(1)) == cap_vl;
  assign work_ins   = elem_insert(work, cap_sew, wr_idx,
                                  elem_extract(cap_vs2, cap_sew, rd_idx));

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          // Nothing to scan: result is vd_old, report it next cycle.
          state_nxt = (vl_clamped == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (last) begin
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs
  // --------------------------------------------------------------------------
  always_comb begin
    busy = (state == RUN) || (state == DONE);
    done = (state == DONE);
  end

  // --------------------------------------------------------------------------
  // Datapath: capture, per-element compress, result publication
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cap_vs2 <= '0;
      cap_vs1 <= '0;
      cap_sew <= '0;
      cap_vl  <= '0;
      work    <= '0;
      rd_idx  <= '0;
      wr_idx  <= '0;
      vd      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            cap_vs2 <= vs2;
            cap_vs1 <= vs1;
            cap_sew <= vsew;
            cap_vl  <= vl_clamped;
            work    <= vd_old;
            rd_idx  <= '0;
            wr_idx  <= '0;
            if (vl_clamped == '0) begin
              vd <= vd_old;
            end
          end
        end
        RUN: begin
          rd_idx <= rd_idx + VLW'(1);
          if (sel) begin
            work   <= work_ins;
            wr_idx <= wr_idx + VLW'(1);
          end
          // The final element lands directly in vd so done can follow next cycle.
          if (last) begin
            vd <= sel ? work_ins : work;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule : vector_compress_unit
`default_nettype wire

// File: tb/tb_vector_compress_unit.sv
`default_nettype none
// ============================================================================
// Module    : tb_vector_compress_unit
// Purpose   : Self-checking bench for vector_compress_unit (and its
//             register-wrapped shell). Expected results come from a
//             behavioural compress model and are queued at issue time;
//             monitors pop and compare on every done pulse.
// Revision  : 1.0 - initial release
// ============================================================================
module tb_vector_compress_unit;

  import riscv_v_pkg::*;

  localparam int VW = $clog2(VLEN / 8) + 1;

  logic            clock   = 1'b0;
  logic            reset_n = 1'b0;
  logic            start   = 1'b0;
  logic [1:0]      vsew    = '0;
  logic [VW-1:0]   vl      = '0;
  logic [VLEN-1:0] vs2     = '0;
  logic [VLEN-1:0] vs1     = '0;
  logic [VLEN-1:0] vd_old  = '0;
  logic            busy;
  logic            done;
  logic [VLEN-1:0] vd;
  logic            f_busy;
  logic            f_done;
  logic [VLEN-1:0] f_vd;

  vector_compress_unit dut (
    .clock (clock), .reset_n (reset_n), .start (start), .vsew (vsew),
    .vl (vl), .vs2 (vs2), .vs1 (vs1), .vd_old (vd_old),
    .busy (busy), .done (done), .vd (vd)
  );

  vector_compress_unit_freq dut_freq (
    .clock (clock), .reset_n (reset_n), .start (start), .vsew (vsew),
    .vl (vl), .vs2 (vs2), .vs1 (vs1), .vd_old (vd_old),
    .busy (f_busy), .done (f_done), .vd (f_vd)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [VLEN-1:0] vd;
    int              cyc;
  } exp_t;

  exp_t            sb[$];
  logic [VLEN-1:0] sb_f[$];
  exp_t            mon_e;
  logic [VLEN-1:0] mon_f;

  task automatic check(input string name, input logic [VLEN-1:0] act,
                       input logic [VLEN-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [VLEN-1:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic int eff_vl(input int sew, input int vlv);
    int vmax;
    vmax = VLEN / (8 << sew);
    return (vlv > vmax) ? vmax : vlv;
  endfunction

  // Reference vcompress: walk the active elements, copy each selected one
  // into the next free destination slot; untouched slots keep vd_old.
  function automatic logic [VLEN-1:0] model(input int sew, input int vlv,
                                            input logic [VLEN-1:0] a,
                                            input logic [VLEN-1:0] m,
                                            input logic [VLEN-1:0] o);
    logic [VLEN-1:0] res;
    int w;
    int n;
    int k;
    w   = 8 << sew;
    n   = eff_vl(sew, vlv);
    k   = 0;
    res = o;
    for (int i = 0; i < n; i++) begin
      if (m[i]) begin
        for (int b = 0; b < w; b++) res[k * w + b] = a[i * w + b];
        k++;
      end
    end
    return res;
  endfunction

  // Monitor for the bare core: value and exact done cycle.
  always @(negedge clock) begin
    if (done) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got done at cycle %0d want no done", cyc);
      end else begin
        mon_e = sb.pop_front();
        check("vd", vd, mon_e.vd);
        check("done_cycle", VLEN'(cyc), VLEN'(mon_e.cyc));
      end
    end
  end

  // Monitor for the register-wrapped shell: value only.
  always @(negedge clock) begin
    if (f_done) begin
      if (sb_f.size() == 0) begin
        total++;
        bad++;
        $display("FAIL freq_unexpected_done: got done at cycle %0d want no done", cyc);
      end else begin
        mon_f = sb_f.pop_front();
        check("freq_vd", f_vd, mon_f);
      end
    end
  end

  // Issue one accepted request; inputs are scrambled right after so a late
  // input change would corrupt the result.
  task automatic issue(input int sew, input int vlv, input logic [VLEN-1:0] a,
                       input logic [VLEN-1:0] m, input logic [VLEN-1:0] o);
    exp_t e;
    @(negedge clock);
    vsew   = 2'(sew);
    vl     = VW'(vlv);
    vs2    = a;
    vs1    = m;
    vd_old = o;
    start  = 1'b1;
    e.vd   = model(sew, vlv, a, m, o);
    e.cyc  = cyc + eff_vl(sew, vlv) + 1;
    sb.push_back(e);
    sb_f.push_back(e.vd);
    @(negedge clock);
    start  = 1'b0;
    vsew   = 2'($urandom);
    vl     = VW'($urandom);
    vs2    = rnd128();
    vs1    = rnd128();
    vd_old = rnd128();
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((sb.size() != 0 || sb_f.size() != 0) && t < 200) begin
      @(negedge clock);
      t++;
    end
    if (sb.size() != 0 || sb_f.size() != 0) begin
      total++;
      bad++;
      $display("FAIL timeout: got %0d pending results want 0", sb.size() + sb_f.size());
      sb.delete();
      sb_f.delete();
    end
    @(negedge clock);
  endtask

  initial begin
    logic [VLEN-1:0] a;
    int s;

    // Reset state
    repeat (3) @(negedge clock);
    check("rst_busy", {127'b0, busy}, '0);
    check("rst_done", {127'b0, done}, '0);
    check("rst_vd", vd, '0);
    reset_n = 1'b1;
    @(negedge clock);

    // e8, vl=16, alternating mask, bytes i=i
    for (int i = 0; i < 16; i++) a[i*8 +: 8] = 8'(i);
    issue(0, 16, a, {112'b0, 16'hAAAA}, rnd128());
    wait_idle();

    // e32, vl=4, empty mask -> vd_old
    issue(2, 4, rnd128(), '0, rnd128());
    wait_idle();

    // e64, vl=2, both selected
    issue(3, 2, rnd128(), {126'b0, 2'b11}, rnd128());
    wait_idle();

    // e16, vl=0 -> done one cycle after start, busy for one cycle
    issue(1, 0, rnd128(), rnd128(), rnd128());
    check("vl0_busy", {127'b0, busy}, {127'b0, 1'b1});
    @(negedge clock);
    check("vl0_busy_after", {127'b0, busy}, '0);
    wait_idle();

    // Reset in the middle of an operation
    issue(0, 16, rnd128(), rnd128(), rnd128());
    repeat (4) @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    check("midrst_busy", {127'b0, busy}, '0);
    check("midrst_done", {127'b0, done}, '0);
    check("midrst_vd", vd, '0);
    check("midrst_freq_vd", f_vd, '0);
    sb.delete();
    sb_f.delete();
    @(negedge clock);
    reset_n = 1'b1;
    issue(0, 16, rnd128(), rnd128(), rnd128());
    wait_idle();

    // e8, vl=20 clamps to 16; a start while busy must be ignored
    issue(0, 20, rnd128(), rnd128(), rnd128());
    s = cyc - 1;
    while (cyc < s + 3) @(negedge clock);
    vsew   = 2'd2;
    vl     = VW'(3);
    vs2    = rnd128();
    vs1    = rnd128();
    vd_old = rnd128();
    start  = 1'b1;
    @(negedge clock);
    start  = 1'b0;
    wait_idle();

    // Randomized operations
    repeat (30) begin
      issue(int'($urandom_range(0, 3)), int'($urandom_range(0, (1 << VW) - 1)),
            rnd128(), rnd128(), rnd128());
      wait_idle();
      repeat ($urandom_range(0, 2)) @(negedge clock);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_vector_compress_unit
`default_nettype wire
